// File: rtl/alu_arbiter.sv
// Shares one single-cycle ALU between two requesters using round-robin arbitration and a one-entry response buffer.
// Accept edge N gives rspN_valid from edge N; an unconsumed response blocks both requesters until its owner is ready.
module alu_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [3:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_op,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b1010;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t state;
    logic   rsp_owner;
    logic   last_grant;
    logic   owner_rdy;
    logic   slot_free;
    logic   grant0;
    logic   grant1;
    logic   op_legal;

    always_comb begin
        owner_rdy = rsp_owner ? rsp1_ready : rsp0_ready;
        // Gated by rst_n so no request is acknowledged while held in reset.
        slot_free = rst_n && ((state == EMPTY) || owner_rdy);
        grant0    = slot_free && req0_valid && (!req1_valid || last_grant);
        grant1    = slot_free && req1_valid && (!req0_valid || !last_grant);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        alu_a  = 32'd0;
        alu_b  = 32'd0;
        alu_op = 4'b0000;
        if (grant0) begin
            alu_a  = req0_a;
            alu_b  = req0_b;
            alu_op = req0_op;
        end else if (grant1) begin
            alu_a  = req1_a;
            alu_b  = req1_b;
            alu_op = req1_op;
        end
    end

    always_comb begin
        case (alu_op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SRL: op_legal = 1'b1;
            default:                               op_legal = 1'b0;
        endcase
    end

    // A drain and a new capture may share an edge, giving one op per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_result <= 32'd0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_owner  <= 1'b0;
            last_grant <= 1'b1;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (grant0 || grant1) begin
            state      <= FULL;
            rsp0_valid <= grant0;
            rsp1_valid <= grant1;
            rsp_result <= op_legal ? alu_result : 32'd0;
            rsp_zero   <= op_legal ? alu_zero : 1'b1;
            rsp_err    <= !op_legal;
            rsp_owner  <= grant1;
            last_grant <= grant1;
            if (grant0 && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
            if (grant1 && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
        end else if (state == FULL && owner_rdy) begin
            state      <= EMPTY;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU model attached.
module tb_alu_arbiter;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [31:0]      req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]       req0_op = '0, req1_op = '0;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [31:0]      rsp_result;
    logic             rsp_zero, rsp_err;
    logic [31:0]      alu_a, alu_b, alu_result;
    logic [3:0]       alu_op;
    logic             alu_zero;
    logic [CNT_W-1:0] grant_cnt0, grant_cnt1;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    // Reference ALU; illegal opcodes yield garbage the arbiter must suppress.
    always_comb begin
        case (alu_op)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b1010: alu_result = alu_a >> alu_b[4:0];
            default: alu_result = 32'hDEADBEEF;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fails++; $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready); end
        n_checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_fails++; $display("FAIL reset_rsp_valid: got %b%b expected 00", rsp0_valid, rsp1_valid); end
        n_checks++; if (rsp_result !== 32'd0 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin n_fails++; $display("FAIL reset_rsp: got %h/%b/%b expected 0/0/0", rsp_result, rsp_zero, rsp_err); end
        n_checks++; if (grant_cnt0 !== 4'd0 || grant_cnt1 !== 4'd0) begin n_fails++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", grant_cnt0, grant_cnt1); end
        do_reset();
    endtask

    task automatic test_single_op();
        do_reset();
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 4'b0010; rsp0_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fails++; $display("FAIL single_ready: got %b%b expected 10", req0_ready, req1_ready); end
        n_checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_op !== 4'b0010) begin n_fails++; $display("FAIL single_alu_drive: got %h %h %h expected 5 7 2", alu_a, alu_b, alu_op); end
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin n_fails++; $display("FAIL single_rsp_valid: got %b%b expected 10", rsp0_valid, rsp1_valid); end
        n_checks++; if (rsp_result !== 32'd12 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin n_fails++; $display("FAIL single_rsp: got %h/%b/%b expected c/0/0", rsp_result, rsp_zero, rsp_err); end
        n_checks++; if (grant_cnt0 !== 4'd1) begin n_fails++; $display("FAIL single_cnt0: got %0d expected 1", grant_cnt0); end
        n_checks++; if (alu_a !== 32'd0 || alu_op !== 4'b0000) begin n_fails++; $display("FAIL idle_alu_drive: got %h %h expected 0 0", alu_a, alu_op); end
        step();
        @(negedge clk);
        n_checks++; if (rsp0_valid !== 1'b0) begin n_fails++; $display("FAIL single_drain: got %b expected 0", rsp0_valid); end
    endtask

    task automatic test_round_robin();
        logic exp_g;
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd9;    req0_b = 32'd9;    req0_op = 4'b0110;
        req1_valid = 1'b1; req1_a = 32'hF0;   req1_b = 32'h0F;   req1_op = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            exp_g = i[0];
            n_checks++; if (req0_ready !== !exp_g || req1_ready !== exp_g) begin n_fails++; $display("FAIL rr_grant[%0d]: got %b%b expected %b%b", i, req0_ready, req1_ready, !exp_g, exp_g); end
            if (i > 0) begin
                n_checks++; if (rsp0_valid !== exp_g || rsp1_valid !== !exp_g) begin n_fails++; $display("FAIL rr_rsp_valid[%0d]: got %b%b expected %b%b", i, rsp0_valid, rsp1_valid, exp_g, !exp_g); end
                n_checks++; if (rsp_result !== (exp_g ? 32'd0 : 32'hFF) || rsp_zero !== exp_g) begin n_fails++; $display("FAIL rr_rsp[%0d]: got %h/%b expected %h/%b", i, rsp_result, rsp_zero, exp_g ? 32'd0 : 32'hFF, exp_g); end
            end
            step();
        end
        n_checks++; if (grant_cnt0 !== 4'd3 || grant_cnt1 !== 4'd2) begin n_fails++; $display("FAIL rr_cnt: got %0d/%0d expected 3/2", grant_cnt0, grant_cnt1); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        req1_valid = 1'b1; req1_a = 32'h80000000; req1_b = 32'd4; req1_op = 4'b1010;
        @(negedge clk);
        n_checks++; if (req1_ready !== 1'b1) begin n_fails++; $display("FAIL bp_accept: got %b expected 1", req1_ready); end
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'hFF; req0_b = 32'h0F; req0_op = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (req0_ready !== 1'b0) begin n_fails++; $display("FAIL bp_blocked[%0d]: got %b expected 0", i, req0_ready); end
            n_checks++; if (rsp1_valid !== 1'b1 || rsp_result !== 32'h08000000) begin n_fails++; $display("FAIL bp_hold[%0d]: got %b/%h expected 1/08000000", i, rsp1_valid, rsp_result); end
            step();
        end
        rsp1_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (req0_ready !== 1'b1) begin n_fails++; $display("FAIL bp_resume: got %b expected 1", req0_ready); end
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_result !== 32'h0F) begin n_fails++; $display("FAIL bp_next_rsp: got %b%b/%h expected 10/0000000f", rsp0_valid, rsp1_valid, rsp_result); end
    endtask

    task automatic test_illegal_op();
        do_reset();
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd3; req0_op = 4'b1111;
        @(negedge clk);
        n_checks++; if (req0_ready !== 1'b1) begin n_fails++; $display("FAIL illegal_accept: got %b expected 1", req0_ready); end
        step();
        rsp0_ready = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 4'b0010;
        @(negedge clk);
        n_checks++; if (rsp0_valid !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b1 || rsp_err !== 1'b1) begin n_fails++; $display("FAIL illegal_rsp: got %b/%h/%b/%b expected 1/0/1/1", rsp0_valid, rsp_result, rsp_zero, rsp_err); end
        n_checks++; if (grant_cnt0 !== 4'd1) begin n_fails++; $display("FAIL illegal_cnt: got %0d expected 1", grant_cnt0); end
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (rsp_result !== 32'd2 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin n_fails++; $display("FAIL illegal_then_legal: got %h/%b/%b expected 2/0/0", rsp_result, rsp_zero, rsp_err); end
    endtask

    task automatic test_saturation();
        do_reset();
        rsp1_ready = 1'b1;
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd2; req1_op = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 14) begin
                n_checks++; if (grant_cnt1 !== 4'd15) begin n_fails++; $display("FAIL sat_reach: got %0d expected 15", grant_cnt1); end
            end
        end
        req1_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (grant_cnt1 !== 4'd15 || grant_cnt0 !== 4'd0) begin n_fails++; $display("FAIL sat_hold: got %0d/%0d expected 0/15", grant_cnt0, grant_cnt1); end
        n_checks++; if (rsp1_valid !== 1'b1 || rsp_result !== 32'd3) begin n_fails++; $display("FAIL sat_rsp: got %b/%h expected 1/3", rsp1_valid, rsp_result); end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3; req0_op = 4'b0010;
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (rsp0_valid !== 1'b1 || grant_cnt0 !== 4'd1) begin n_fails++; $display("FAIL mid_pre: got %b/%0d expected 1/1", rsp0_valid, grant_cnt0); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (rsp0_valid !== 1'b0 || grant_cnt0 !== 4'd0 || rsp_result !== 32'd0) begin n_fails++; $display("FAIL mid_async: got %b/%0d/%h expected 0/0/0", rsp0_valid, grant_cnt0, rsp_result); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req1_a = 32'hC; req1_b = 32'hA; req1_op = 4'b0000;
        @(negedge clk);
        n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fails++; $display("FAIL mid_first_tie: got %b%b expected 10", req0_ready, req1_ready); end
        step();
        @(negedge clk);
        n_checks++; if (req1_ready !== 1'b1 || rsp0_valid !== 1'b1 || rsp_result !== 32'd5) begin n_fails++; $display("FAIL mid_second: got %b/%b/%h expected 1/1/5", req1_ready, rsp0_valid, rsp_result); end
        step();
        clear_inputs();
        @(negedge clk);
        n_checks++; if (rsp1_valid !== 1'b1 || rsp_result !== 32'h8) begin n_fails++; $display("FAIL mid_req1_rsp: got %b/%h expected 1/8", rsp1_valid, rsp_result); end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_back_pressure();
        test_illegal_op();
        test_saturation();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
